// File: rtl/dsp_opmode_sequencer.sv
// Sequencer for one DSP48A1 slice (AREG=BREG=0, MREG=1, PREG=1): streams one MAC job's operands
// and OPMODE words, flushes the slice pipeline and captures P as the job result.
module dsp_opmode_sequencer #(
   parameter int unsigned Dw     = 18,
   parameter int unsigned LenW   = 10,
   parameter int unsigned OpmDly = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [LenW-1:0] cmd_len_i,
   input  logic            cmd_preload_i,
   input  logic            cmd_sub_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [Dw-1:0]   in_a_i,
   input  logic [Dw-1:0]   in_b_i,
   output logic [Dw-1:0]   dsp_a_o,
   output logic [Dw-1:0]   dsp_b_o,
   output logic [7:0]      dsp_opmode_o,
   output logic            dsp_ce_o,
   input  logic [47:0]     p_in_i,
   output logic [47:0]     result_o,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic            busy_o
);

   localparam logic [7:0] OpmFlush = 8'b0000_1000;  // Z=P, X=0: P holds
   localparam int unsigned FlushCntW = $clog2(OpmDly + 2);
   // Flush issues OpmDly+1 words; the count reaching this value is the capture cycle.
   localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(OpmDly + 1);

   typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDone} state_e;

   state_e state_q, state_d;

   logic [LenW-1:0]      remain_q, remain_d;
   logic                 first_q, first_d;
   logic                 preload_q, preload_d;
   logic                 sub_q, sub_d;
   logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
   logic [Dw-1:0]        dsp_a_q, dsp_a_d;
   logic [Dw-1:0]        dsp_b_q, dsp_b_d;
   logic                 dsp_ce_q;
   logic [7:0]           dsp_opmode_q;
   logic [7:0]           opm_dly_q [OpmDly];
   logic [47:0]          result_q, result_d;

   logic                 accept;
   logic                 issue;     // push one word into the slice at this edge
   logic [7:0]           issue_opm;
   logic                 capture;
   logic [7:0]           word_first;
   logic [7:0]           word_later;

   assign accept     = in_valid_i & in_ready_o;
   assign word_first = {sub_q, 3'b000, (preload_q ? 2'b11 : 2'b00), 2'b01};
   assign word_later = {sub_q, 3'b000, 2'b10, 2'b01};
   assign capture    = (state_q == StFlush) && (flush_cnt_q == FlushLast);

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cmd_valid_i) state_d = StAccum;
         StAccum: begin
            // Zero-length jobs leave after their single zero-operand word.
            if ((remain_q == '0) || (accept && (remain_q == LenW'(1)))) state_d = StFlush;
         end
         StFlush: if (capture) state_d = StDone;
         StDone:  if (result_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      cmd_ready_o    = (state_q == StIdle);
      in_ready_o     = (state_q == StAccum) && (remain_q != '0);
      result_valid_o = (state_q == StDone);
      busy_o         = (state_q != StIdle);
   end

   // Datapath next-state: job registers, operand issue, result capture
   always_comb begin
      remain_d    = remain_q;
      first_d     = first_q;
      preload_d   = preload_q;
      sub_d       = sub_q;
      flush_cnt_d = flush_cnt_q;
      dsp_a_d     = dsp_a_q;
      dsp_b_d     = dsp_b_q;
      result_d    = result_q;
      issue       = 1'b0;
      issue_opm   = OpmFlush;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               remain_d    = cmd_len_i;
               first_d     = 1'b1;
               preload_d   = cmd_preload_i;
               sub_d       = cmd_sub_i;
               flush_cnt_d = '0;
            end
         end
         StAccum: begin
            if (accept) begin
               issue     = 1'b1;
               issue_opm = first_q ? word_first : word_later;
               dsp_a_d   = in_a_i;
               dsp_b_d   = in_b_i;
               remain_d  = remain_q - LenW'(1);
               first_d   = 1'b0;
            end else if (remain_q == '0) begin
               issue     = 1'b1;
               issue_opm = word_first;
               dsp_a_d   = '0;
               dsp_b_d   = '0;
               first_d   = 1'b0;
            end
         end
         StFlush: begin
            if (capture) begin
               result_d = p_in_i;
            end else begin
               issue       = 1'b1;
               dsp_a_d     = '0;
               dsp_b_d     = '0;
               flush_cnt_d = flush_cnt_q + FlushCntW'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; the opmode delay line only advances with the slice clock enable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         remain_q     <= '0;
         first_q      <= 1'b0;
         preload_q    <= 1'b0;
         sub_q        <= 1'b0;
         flush_cnt_q  <= '0;
         dsp_a_q      <= '0;
         dsp_b_q      <= '0;
         dsp_ce_q     <= 1'b0;
         dsp_opmode_q <= '0;
         result_q     <= '0;
         for (int unsigned i = 0; i < OpmDly; i++) opm_dly_q[i] <= '0;
      end else begin
         remain_q    <= remain_d;
         first_q     <= first_d;
         preload_q   <= preload_d;
         sub_q       <= sub_d;
         flush_cnt_q <= flush_cnt_d;
         dsp_a_q     <= dsp_a_d;
         dsp_b_q     <= dsp_b_d;
         dsp_ce_q    <= issue;
         result_q    <= result_d;
         if (issue) begin
            dsp_opmode_q <= opm_dly_q[OpmDly-1];
            for (int unsigned i = OpmDly - 1; i > 0; i--) opm_dly_q[i] <= opm_dly_q[i-1];
            opm_dly_q[0] <= issue_opm;
         end
      end
   end

   assign dsp_a_o      = dsp_a_q;
   assign dsp_b_o      = dsp_b_q;
   assign dsp_ce_o     = dsp_ce_q;
   assign dsp_opmode_o = dsp_opmode_q;
   assign result_o     = result_q;

endmodule

// File: tb/tb_dsp_opmode_sequencer.sv
// Bench for dsp_opmode_sequencer: behavioural DSP48A1 slice, randomized jobs checked against
// the arithmetic result (C or 0) +/- sum(a*b) mod 2**48 and the opmode word rules.
module tb_dsp_opmode_sequencer;

   localparam int unsigned Dw     = 18;
   localparam int unsigned LenW   = 10;
   localparam int unsigned OpmDly = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid, cmd_ready;
   logic [LenW-1:0] cmd_len;
   logic            cmd_preload, cmd_sub;
   logic            in_valid, in_ready;
   logic [Dw-1:0]   in_a, in_b;
   logic [Dw-1:0]   dsp_a, dsp_b;
   logic [7:0]      dsp_opmode;
   logic            dsp_ce;
   logic [47:0]     p_in;
   logic [47:0]     result;
   logic            result_valid, result_ready;
   logic            busy;
   logic [47:0]     c_port;

   int n_checks = 0;
   int n_errors = 0;

   logic [Dw-1:0] sa [$];
   logic [Dw-1:0] sb [$];

   always #5 clk = ~clk;

   dsp_opmode_sequencer #(
      .Dw    (Dw),
      .LenW  (LenW),
      .OpmDly(OpmDly)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_len_i     (cmd_len),
      .cmd_preload_i (cmd_preload),
      .cmd_sub_i     (cmd_sub),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_a_i        (in_a),
      .in_b_i        (in_b),
      .dsp_a_o       (dsp_a),
      .dsp_b_o       (dsp_b),
      .dsp_opmode_o  (dsp_opmode),
      .dsp_ce_o      (dsp_ce),
      .p_in_i        (p_in),
      .result_o      (result),
      .result_valid_o(result_valid),
      .result_ready_i(result_ready),
      .busy_o        (busy)
   );

   // Behavioural DSP48A1 subset: M and P registers, X in {0,M}, Z in {0,P,C}, optional post-sub
   function automatic logic [47:0] post_add(input logic [7:0] opm, input logic [47:0] m,
                                            input logic [47:0] p, input logic [47:0] c);
      logic [47:0] x, z;
      x = (opm[1:0] == 2'b01) ? m : 48'd0;
      case (opm[3:2])
         2'b10:   z = p;
         2'b11:   z = c;
         default: z = 48'd0;
      endcase
      return opm[7] ? z - x : z + x;
   endfunction

   logic signed [35:0] m_q;
   logic [47:0]        p_q;

   always @(posedge clk) begin
      if (rst) begin
         m_q <= '0;
         p_q <= '0;
      end else if (dsp_ce) begin
         m_q <= $signed(dsp_a) * $signed(dsp_b);
         p_q <= post_add(dsp_opmode, {{12{m_q[35]}}, m_q}, p_q, c_port);
      end
   end

   assign p_in = p_q;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_sample(input int a, input int b);
      sa.push_back(Dw'(a));
      sb.push_back(Dw'(b));
   endtask

   // Word the slice must see on the j-th enabled cycle of a job, from the opmode rules
   function automatic logic [7:0] exp_word(input int j, input int len, input bit pre,
                                           input bit sub);
      int len_eff;
      len_eff = (len == 0) ? 1 : len;
      if (j >= len_eff) return 8'b0000_1000;
      if (j == 0) return {sub, 3'b000, (pre ? 2'b11 : 2'b00), 2'b01};
      return {sub, 3'b000, 2'b10, 2'b01};
   endfunction

   task automatic run_job(input string tag, input int len, input bit pre, input bit sub,
                          input logic [47:0] c, input int gap_pct, input bit hold,
                          output logic [47:0] got_res);
      logic [47:0] exp_res;
      longint      prod;
      int          idx, ce_n, last_ce, cyc, len_eff, hold_n;
      bit          offer, gap, done;
      exp_res = pre ? c : 48'd0;
      for (int k = 0; k < len; k++) begin
         prod    = longint'($signed(sa[k])) * longint'($signed(sb[k]));
         exp_res = sub ? exp_res - 48'(prod) : exp_res + 48'(prod);
      end
      len_eff = (len == 0) ? 1 : len;
      c_port  = c;
      check_eq({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
      cmd_valid   = 1'b1;
      cmd_len     = LenW'(len);
      cmd_preload = pre;
      cmd_sub     = sub;
      tick();
      cmd_valid   = 1'b0;
      cmd_len     = LenW'($urandom);
      cmd_preload = 1'($urandom);
      cmd_sub     = 1'($urandom);
      check_eq({tag, ".busy"}, 64'(busy), 64'd1);
      idx = 0; ce_n = 0; last_ce = -1; gap = 1'b0; done = 1'b0; cyc = 0;
      for (cyc = 0; cyc < 400; cyc++) begin
         if (gap) check_eq({tag, ".gap_ce"}, 64'(dsp_ce), 64'd0);
         if (dsp_ce) begin
            check_eq({tag, ".dsp_a"}, 64'(dsp_a), (ce_n < len) ? 64'(sa[ce_n]) : 64'd0);
            check_eq({tag, ".dsp_b"}, 64'(dsp_b), (ce_n < len) ? 64'(sb[ce_n]) : 64'd0);
            if (ce_n >= int'(OpmDly))
               check_eq({tag, ".opmode"}, 64'(dsp_opmode),
                        64'(exp_word(ce_n - int'(OpmDly), len, pre, sub)));
            ce_n++;
            last_ce = cyc;
         end
         if (result_valid) begin
            done = 1'b1;
            break;
         end
         check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(idx < len));
         offer    = (idx < len) && ($urandom_range(99) >= gap_pct);
         gap      = (idx < len) && !offer;
         in_valid = offer ? 1'b1 : ((idx >= len) ? 1'($urandom) : 1'b0);
         in_a     = offer ? sa[idx] : Dw'($urandom);
         in_b     = offer ? sb[idx] : Dw'($urandom);
         if (offer) idx++;
         tick();
      end
      in_valid = 1'b0;
      got_res  = result;
      check_eq({tag, ".done_seen"}, 64'(done), 64'd1);
      if (done) begin
         check_eq({tag, ".result"}, 64'(result), 64'(exp_res));
         check_eq({tag, ".ce_cycles"}, 64'(ce_n), 64'(len_eff + int'(OpmDly) + 1));
         check_eq({tag, ".valid_lat"}, 64'(cyc - last_ce), 64'd1);
         check_eq({tag, ".cmd_ready_done"}, 64'(cmd_ready), 64'd0);
         hold_n = hold ? 6 : int'($urandom_range(0, 2));
         for (int h = 0; h < hold_n; h++) begin
            result_ready = 1'b0;
            cmd_valid    = 1'b1;
            in_valid     = 1'b1;
            tick();
            check_eq({tag, ".hold_valid"}, 64'(result_valid), 64'd1);
            check_eq({tag, ".hold_result"}, 64'(result), 64'(exp_res));
            check_eq({tag, ".hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
            check_eq({tag, ".hold_ce"}, 64'(dsp_ce), 64'd0);
         end
         cmd_valid    = 1'b0;
         in_valid     = 1'b0;
         result_ready = 1'b1;
         tick();
         result_ready = 1'b0;
         check_eq({tag, ".released"}, 64'(result_valid), 64'd0);
         check_eq({tag, ".idle_ready"}, 64'(cmd_ready), 64'd1);
         check_eq({tag, ".idle_busy"}, 64'(busy), 64'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".dsp_a"}, 64'(dsp_a), 64'd0);
      check_eq({tag, ".dsp_b"}, 64'(dsp_b), 64'd0);
      check_eq({tag, ".opmode"}, 64'(dsp_opmode), 64'd0);
      check_eq({tag, ".ce"}, 64'(dsp_ce), 64'd0);
      check_eq({tag, ".result"}, 64'(result), 64'd0);
      check_eq({tag, ".valid"}, 64'(result_valid), 64'd0);
      check_eq({tag, ".busy"}, 64'(busy), 64'd0);
      check_eq({tag, ".in_ready"}, 64'(in_ready), 64'd0);
      check_eq({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] res;
      int          len;
      rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_preload = 1'b0; cmd_sub = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; result_ready = 1'b0; c_port = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_reset_outputs("reset");

      // 1: plain MAC
      sa.delete(); sb.delete();
      add_sample(2, 3); add_sample(4, 5); add_sample(-1, 7); add_sample(10, 10);
      run_job("t1", 4, 1'b0, 1'b0, 48'd777, 0, 1'b0, res);
      check_eq("t1.spec", 64'(res), 64'd119);

      // 2: C preload
      sa.delete(); sb.delete();
      add_sample(3, 3); add_sample(5, -2);
      run_job("t2", 2, 1'b1, 1'b0, 48'd1000, 0, 1'b0, res);
      check_eq("t2.spec", 64'(res), 64'd999);

      // 3: gapped input
      sa.delete(); sb.delete();
      for (int k = 1; k <= 8; k++) add_sample(1, k);
      run_job("t3", 8, 1'b0, 1'b0, 48'd5, 45, 1'b0, res);
      check_eq("t3.spec", 64'(res), 64'd36);

      // 4: zero-length job returns C
      sa.delete(); sb.delete();
      run_job("t4", 0, 1'b1, 1'b0, 48'd55, 0, 1'b0, res);
      check_eq("t4.spec", 64'(res), 64'd55);

      // 5: post-subtract
      sa.delete(); sb.delete();
      add_sample(1, 1); add_sample(2, 2); add_sample(3, 3);
      run_job("t5", 3, 1'b0, 1'b1, 48'd9, 0, 1'b0, res);
      check_eq("t5.spec", 64'(res), 64'hFFFF_FFFF_FFF2);

      // 6: reset mid-job, then a held result
      sa.delete(); sb.delete();
      for (int k = 0; k < 5; k++) add_sample(int'($urandom), int'($urandom));
      cmd_valid = 1'b1; cmd_len = LenW'(5); cmd_preload = 1'b0; cmd_sub = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_a = sa[k]; in_b = sb[k];
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("t6.rst");
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("t6.no_valid", 64'(result_valid), 64'd0);
      end
      sa.delete(); sb.delete();
      add_sample(-7, 9); add_sample(100, -3); add_sample(12, 12);
      run_job("t6.hold", 3, 1'b1, 1'b0, 48'd20, 20, 1'b1, res);

      // Randomized jobs
      for (int j = 0; j < 25; j++) begin
         sa.delete(); sb.delete();
         len = int'($urandom_range(0, 12));
         for (int k = 0; k < len; k++) add_sample(int'($urandom), int'($urandom));
         run_job($sformatf("rnd%0d", j), len, 1'($urandom), 1'($urandom),
                 {16'($urandom), 32'($urandom)}, int'($urandom_range(0, 50)), 1'($urandom),
                 res);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
